pt_add_seq: RTL and testbench
=============================

PT_ADD_SEQ -- requirements
Module: pt_add_seq

Interface
REQ-001 SHALL have parameter SIZE, default 32, field-element width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum cycles waited for one field-op completion.
REQ-003 SHALL have ports:
  - i_clk  in  1  clock; reset i_rst, asynchronous, active-low; clock i_clk.
  - i_rst  in  1  async active-low reset.
  - start  in  1  one-cycle request to add P1 and P2.
  - x1, y1, x2, y2  in  SIZE each  affine coordinates of P1 and P2.
  - prime  in  SIZE  field modulus, forwarded to the field unit.
  - busy  out  1  high from the accepted start until done.
  - done  out  1  one-cycle completion pulse.
  - err  out  2  0 = ok, 1 = X1==X2 (unsupported), 2 = timeout.
  - x3, y3  out  SIZE each  result coordinates.
  - gf_in_0, gf_in_1  out  SIZE  field-unit operands.
  - gf_prime  out  SIZE  field-unit modulus.
  - gf_op  out  2  0 add, 1 sub, 2 mult, 3 div (in_0/in_1).
  - gf_start  out  1  field-unit request strobe.
  - gf_result  in  SIZE  field-unit result.
  - gf_done  in  1  field-unit completion; may assert in the same cycle as gf_start (add/sub) or later (mult/div).

Function
REQ-004 SHALL latch x1, y1, x2, y2 and prime into internal X1, Y1, X2, Y2 and P registers when start=1 in IDLE; start outside IDLE SHALL be ignored.
REQ-005 SHALL hold two temporaries, T0 and T1, each SIZE bits.
REQ-006 SHALL run a fixed 9-step program, with step index 0..8:
  - 0: T0=Y2-Y1
  - 1: T1=X2-X1
  - 2: T0=T0/T1
  - 3: T1=T0*T0
  - 4: T1=T1-X1
  - 5: X3=T1-X2
  - 6: T1=X1-X3
  - 7: T1=T0*T1
  - 8: Y3=T1-Y1
REQ-007 SHALL use states IDLE, CHECK, ISSUE, WAIT, FIN.
  - IDLE: on start, go to CHECK.
  - CHECK: if X1==X2, go to FIN with err=1; else go to ISSUE with step=0.
REQ-008 In ISSUE, SHALL drive gf_start=1 for exactly one cycle, with gf_op and operands selected by the current step.
  - If gf_done=1 in that cycle, SHALL capture gf_result into dst and advance.
  - Otherwise SHALL go to WAIT.
REQ-009 In WAIT, SHALL hold gf_start=0 and keep gf_op and operands stable.
  - On gf_done=1, SHALL capture gf_result into dst and advance.
REQ-010 Advance rule: if step==8, go to FIN; else step+1 and go to ISSUE.
REQ-011 SHALL clear a cycle counter on ISSUE and increment it each WAIT cycle; reaching TIMEOUT in WAIT SHALL go to FIN with err=2.
REQ-012 FIN SHALL assert done=1 for one cycle, then return to IDLE; busy SHALL be 0 in that same cycle.
REQ-013 busy SHALL be 1 in CHECK, ISSUE and WAIT.
REQ-014 x3, y3 and err SHALL hold their values until the next accepted start.
  - On err≠0, x3 and y3 SHALL be 0.
  - err SHALL be cleared to 0 on start acceptance.
REQ-015 gf_prime SHALL equal the latched P at all times; gf_done SHALL be ignored outside ISSUE and WAIT.
REQ-016 Latency SHALL be 2 cycles (IDLE→CHECK→ISSUE) plus the sum of per-step cycles plus 1 FIN cycle.
  - Per-step cycles: 1 for a same-cycle gf_done, else 1 + WAIT cycles.

Reset
REQ-017 On i_rst=0, the block SHALL be asynchronously in IDLE with outputs cleared:
  - busy=0, done=0, err=0, gf_start=0, gf_op=0
  - x3=0, y3=0, gf_in_0=0, gf_in_1=0
  - all internal registers 0
REQ-018 Reset asserted mid-operation SHALL abandon the program with no done pulse; after release, the block SHALL accept a new start.

Verification
REQ-019 Nominal add, with a real field unit:
  - stimulus: prime=23, P1=(3,10), P2=(9,7), start pulse
  - response: single done, err=0, x3=17, y3=20; intermediate T0=11 after step 2
REQ-020 Equal x:
  - stimulus: P1=(5,1), P2=(5,22)
  - response: done on the 3rd cycle after start, err=1, x3=y3=0, gf_start never asserted
REQ-021 Timeout, with a field-unit model that never asserts gf_done:
  - stimulus: TIMEOUT=15
  - response: err=2 after 15 WAIT cycles of step 0
REQ-022 Start while busy:
  - stimulus: second start with different operands mid-program
  - response: ignored; result still (17,20); exactly one done pulse
REQ-023 Reset mid-WAIT during step 3:
  - response: all outputs 0 immediately; no done pulse
  - then: the nominal vector rerun yields (17,20)
REQ-024 gf_start pulse count:
  - required: exactly 9 pulses per ok run
  - required: gf_op sequence 1,1,3,2,1,1,1,2,1

Source files
------------

// File: rtl/pt_add_seq_if.sv
// Request/result and field-unit signal bundle for the elliptic-curve point-add sequencer.
// The slave side is the sequencer; the master side is the requester plus the field unit.
interface pt_add_seq_if #(
   parameter int SIZE = 32
);
   logic            start;
   logic [SIZE-1:0] x1;
   logic [SIZE-1:0] y1;
   logic [SIZE-1:0] x2;
   logic [SIZE-1:0] y2;
   logic [SIZE-1:0] prime;
   logic            busy;
   logic            done;
   logic [1:0]      err;
   logic [SIZE-1:0] x3;
   logic [SIZE-1:0] y3;
   logic [SIZE-1:0] gf_in_0;
   logic [SIZE-1:0] gf_in_1;
   logic [SIZE-1:0] gf_prime;
   logic [1:0]      gf_op;
   logic            gf_start;
   logic [SIZE-1:0] gf_result;
   logic            gf_done;

   modport slave (
      input  start, x1, y1, x2, y2, prime, gf_result, gf_done,
      output busy, done, err, x3, y3, gf_in_0, gf_in_1, gf_prime, gf_op, gf_start
   );

   modport master (
      output start, x1, y1, x2, y2, prime, gf_result, gf_done,
      input  busy, done, err, x3, y3, gf_in_0, gf_in_1, gf_prime, gf_op, gf_start
   );
endinterface

// File: rtl/pt_add_seq.sv
// Affine point addition P3 = P1 + P2 sequenced as a fixed 9-step program of
// field operations issued to an external field unit (add/sub/mult/div).
module pt_add_seq #(
   parameter int SIZE    = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic        i_clk,
   input  logic        i_rst,
   pt_add_seq_if.slave bus
);
   localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [1:0]    OP_SUB    = 2'd1;
   localparam logic [1:0]    OP_MUL    = 2'd2;
   localparam logic [1:0]    OP_DIV    = 2'd3;
   localparam logic [1:0]    ERR_OK    = 2'd0;
   localparam logic [1:0]    ERR_EQX   = 2'd1;
   localparam logic [1:0]    ERR_TMO   = 2'd2;
   localparam logic [3:0]    LAST_STEP = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      step_q, step_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, p_q, p_d;
   logic [SIZE-1:0] t0_q, t0_d, t1_q, t1_d, xr_q, xr_d;
   logic            busy_q, busy_d, done_q, done_d, gfs_q, gfs_d;
   logic [1:0]      err_q, err_d, op_q, op_d;
   logic [SIZE-1:0] x3_q, x3_d, y3_q, y3_d, in0_q, in0_d, in1_q, in1_d;
   logic            advance_s, issue_s;

   // Program table: {op, in_0, in_1} for each step; xr is the X3 intermediate.
   function automatic logic [2*SIZE+1:0] step_operands(
      input logic [3:0]      step,
      input logic [SIZE-1:0] x1, y1, x2, t0, t1, xr
   );
      case (step)
         4'd0:    step_operands = {OP_SUB, y2_q, y1};
         4'd1:    step_operands = {OP_SUB, x2, x1};
         4'd2:    step_operands = {OP_DIV, t0, t1};
         4'd3:    step_operands = {OP_MUL, t0, t0};
         4'd4:    step_operands = {OP_SUB, t1, x1};
         4'd5:    step_operands = {OP_SUB, t1, x2};
         4'd6:    step_operands = {OP_SUB, x1, xr};
         4'd7:    step_operands = {OP_MUL, t0, t1};
         4'd8:    step_operands = {OP_SUB, t1, y1};
         default: step_operands = {OP_SUB, {SIZE{1'b0}}, {SIZE{1'b0}}};
      endcase
   endfunction

   // Next-state computation for the sequencer and all of its registered outputs.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      p_d       = p_q;
      t0_d      = t0_q;
      t1_d      = t1_q;
      xr_d      = xr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      gfs_d     = 1'b0;
      err_d     = err_q;
      op_d      = op_q;
      x3_d      = x3_q;
      y3_d      = y3_q;
      in0_d     = in0_q;
      in1_d     = in1_q;
      advance_s = 1'b0;
      issue_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x1_d    = bus.x1;
               y1_d    = bus.y1;
               x2_d    = bus.x2;
               y2_d    = bus.y2;
               p_d     = bus.prime;
               err_d   = ERR_OK;
               busy_d  = 1'b1;
               state_d = S_CHECK;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_CHECK: begin
            // Equal x means doubling or the point at infinity; neither is handled here.
            if (x1_q == x2_q) begin
               state_d = S_FIN;
               err_d   = ERR_EQX;
               x3_d    = {SIZE{1'b0}};
               y3_d    = {SIZE{1'b0}};
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               step_d  = 4'd0;
               issue_s = 1'b1;
            end
         end
         S_ISSUE: begin
            cnt_d = {CW{1'b0}};
            if (bus.gf_done) begin
               advance_s = 1'b1;
            end else begin
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.gf_done) begin
               advance_s = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_FIN;
               err_d     = ERR_TMO;
               x3_d      = {SIZE{1'b0}};
               y3_d      = {SIZE{1'b0}};
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               cnt_d     = cnt_q + CW'(1'b1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (advance_s) begin
         case (step_q)
            4'd0, 4'd2:                   t0_d = bus.gf_result;
            4'd1, 4'd3, 4'd4, 4'd6, 4'd7: t1_d = bus.gf_result;
            4'd5:                         xr_d = bus.gf_result;
            default:                      xr_d = xr_q;
         endcase
         if (step_q == LAST_STEP) begin
            state_d = S_FIN;
            x3_d    = xr_q;
            y3_d    = bus.gf_result;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            step_d  = step_q + 4'd1;
            issue_s = 1'b1;
         end
      end else begin
         advance_s = 1'b0;
      end

      // Operands come from the post-capture values so back-to-back steps see fresh results.
      if (issue_s) begin
         state_d = S_ISSUE;
         gfs_d   = 1'b1;
         {op_d, in0_d, in1_d} = step_operands(step_d, x1_q, y1_q, x2_q, t0_d, t1_d, xr_d);
      end else begin
         issue_s = 1'b0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         step_q  <= 4'd0;
         cnt_q   <= {CW{1'b0}};
         x1_q    <= {SIZE{1'b0}};
         y1_q    <= {SIZE{1'b0}};
         x2_q    <= {SIZE{1'b0}};
         y2_q    <= {SIZE{1'b0}};
         p_q     <= {SIZE{1'b0}};
         t0_q    <= {SIZE{1'b0}};
         t1_q    <= {SIZE{1'b0}};
         xr_q    <= {SIZE{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gfs_q   <= 1'b0;
         err_q   <= 2'd0;
         op_q    <= 2'd0;
         x3_q    <= {SIZE{1'b0}};
         y3_q    <= {SIZE{1'b0}};
         in0_q   <= {SIZE{1'b0}};
         in1_q   <= {SIZE{1'b0}};
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         x2_q    <= x2_d;
         y2_q    <= y2_d;
         p_q     <= p_d;
         t0_q    <= t0_d;
         t1_q    <= t1_d;
         xr_q    <= xr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gfs_q   <= gfs_d;
         err_q   <= err_d;
         op_q    <= op_d;
         x3_q    <= x3_d;
         y3_q    <= y3_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.x3       = x3_q;
   assign bus.y3       = y3_q;
   assign bus.gf_in_0  = in0_q;
   assign bus.gf_in_1  = in1_q;
   assign bus.gf_prime = p_q;
   assign bus.gf_op    = op_q;
   assign bus.gf_start = gfs_q;
endmodule

// File: tb/tb_pt_add_seq.sv
// Bench for pt_add_seq: a behavioural prime-field unit answers the DUT, and results are
// compared with direct affine point-addition arithmetic.
module tb_pt_add_seq;
   localparam int          SIZE    = 16;
   localparam int          TMO     = 15;
   localparam logic [17:0] EXP_OPS = {2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int              fu_lat  = 1;
   bit              fu_slow = 1'b0;
   bit              fu_dead = 1'b0;
   int              fu_cnt  = 0;
   logic [SIZE-1:0] fu_pend;

   pt_add_seq_if #(.SIZE(SIZE)) bus ();

   pt_add_seq #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [SIZE-1:0] p, x1, y1, x2, y2;
      int              lat;
      bit              slow;
      int              err;
      logic [SIZE-1:0] x3, y3;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint unsigned fpow(input longint unsigned b_in, input longint unsigned e_in,
                                            input longint unsigned p);
      longint unsigned r = 1;
      longint unsigned b = b_in % p;
      longint unsigned e = e_in;
      while (e > 0) begin
         if (e[0]) r = (r * b) % p;
         b = (b * b) % p;
         e = e >> 1;
      end
      return r % p;
   endfunction

   function automatic longint unsigned fsub(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned p);
      return (a + p - b) % p;
   endfunction

   function automatic longint unsigned fop(input logic [1:0] op, input longint unsigned a,
                                           input longint unsigned b, input longint unsigned p);
      case (op)
         2'd0:    return (a + b) % p;
         2'd1:    return fsub(a, b, p);
         2'd2:    return (a * b) % p;
         default: return (a * fpow(b, p - 2, p)) % p;
      endcase
   endfunction

   // Reference: lambda = (y2-y1)/(x2-x1), x3 = lambda^2-x1-x2, y3 = lambda(x1-x3)-y1.
   task automatic ref_add(input longint unsigned p, x1, y1, x2, y2,
                          output int err, output longint unsigned x3, y3, lam);
      if (x1 == x2) begin
         err = 1; x3 = 0; y3 = 0; lam = 0;
      end else begin
         err = 0;
         lam = (fsub(y2, y1, p) * fpow(fsub(x2, x1, p), p - 2, p)) % p;
         x3  = fsub(fsub((lam * lam) % p, x1, p), x2, p);
         y3  = fsub((lam * fsub(x1, x3, p)) % p, y1, p);
      end
   endtask

   // Cycles from the start cycle through the done cycle, inclusive.
   function automatic int exp_latency(input int err, input int lat, input bit slow);
      logic [17:0] seq;
      logic [1:0]  op;
      int          c;
      seq = EXP_OPS;
      if (err == 1) return 3;
      if (err == 2) return 2 + (1 + TMO) + 1;
      c = 3;
      for (int s = 0; s < 9; s++) begin
         op = seq[17 - 2*s -: 2];
         c += (op < 2'd2 && !slow) ? 1 : 1 + lat;
      end
      return c;
   endfunction

   // Field unit: add/sub answer in the issue cycle unless slow; others after fu_lat waits.
   initial begin
      bus.gf_done   = 1'b0;
      bus.gf_result = {SIZE{1'b0}};
      forever begin
         @(negedge i_clk);
         if (!i_rst) begin
            bus.gf_done = 1'b0;
            fu_cnt      = 0;
         end else if (bus.gf_start) begin
            fu_pend = SIZE'(fop(bus.gf_op, longint'(bus.gf_in_0), longint'(bus.gf_in_1),
                                longint'(bus.gf_prime)));
            if (fu_dead) begin
               bus.gf_done = 1'b0;
               fu_cnt      = 0;
            end else if (bus.gf_op < 2'd2 && !fu_slow) begin
               bus.gf_result = fu_pend;
               bus.gf_done   = 1'b1;
               fu_cnt        = 0;
            end else begin
               bus.gf_done = 1'b0;
               fu_cnt      = fu_lat;
            end
         end else if (fu_cnt > 0) begin
            fu_cnt--;
            bus.gf_done = (fu_cnt == 0);
            if (fu_cnt == 0) bus.gf_result = fu_pend;
         end else begin
            bus.gf_done = 1'b0;
         end
      end
   end

   task automatic run_point(input string tag, input logic [SIZE-1:0] p, x1, y1, x2, y2,
                            input int lat, input bit slow, input bit dead, input bit mid,
                            input int exp_err, input logic [SIZE-1:0] ex3, ey3, elam);
      int          n, pulses, dones, done_at, exp_pulses;
      logic [17:0] ops_v;
      logic [SIZE-1:0] lam_seen;
      fu_lat = lat; fu_slow = slow; fu_dead = dead;
      @(negedge i_clk);
      bus.start = 1'b1; bus.x1 = x1; bus.y1 = y1; bus.x2 = x2; bus.y2 = y2; bus.prime = p;
      @(posedge i_clk); #1;
      bus.start = 1'b0;
      n = 1; pulses = 0; dones = 0; done_at = 0; ops_v = 18'd0; lam_seen = {SIZE{1'b0}};
      check({tag, "/busy_in_check"}, 64'(bus.busy), 64'd1);
      while (n < 300 && !(dones > 0 && n >= done_at + 3)) begin
         if (mid && (n == 6 || n == 7)) begin
            bus.start = (n == 6);
            bus.x1 = 16'd1; bus.y1 = 16'd2; bus.x2 = 16'd4; bus.y2 = 16'd1; bus.prime = 16'd97;
         end
         if (bus.gf_start) begin
            if (pulses < 9) ops_v = {ops_v[15:0], bus.gf_op};
            if (pulses == 3) lam_seen = bus.gf_in_0;
            pulses++;
         end
         if (bus.done) begin
            dones++;
            if (dones == 1) begin
               done_at = n;
               check({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
            end
         end
         @(posedge i_clk); #1;
         n++;
      end
      exp_pulses = (exp_err == 0) ? 9 : ((exp_err == 2) ? 1 : 0);
      check({tag, "/done_pulses"}, 64'(dones), 64'd1);
      check({tag, "/latency"}, 64'(done_at + 1), 64'(exp_latency(exp_err, lat, slow)));
      check({tag, "/err"}, 64'(bus.err), 64'(exp_err));
      check({tag, "/x3"}, 64'(bus.x3), 64'(ex3));
      check({tag, "/y3"}, 64'(bus.y3), 64'(ey3));
      check({tag, "/gf_start_pulses"}, 64'(pulses), 64'(exp_pulses));
      check({tag, "/gf_prime"}, 64'(bus.gf_prime), 64'(p));
      if (exp_err == 0) begin
         check({tag, "/op_sequence"}, 64'(ops_v), 64'(EXP_OPS));
         check({tag, "/lambda"}, 64'(lam_seen), 64'(elam));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t            tbl[6];
      int              rerr;
      longint unsigned rx3, ry3, rlam;
      logic [SIZE-1:0] primes[6];
      logic [SIZE-1:0] p, x1, y1, x2, y2;
      int              k, pulses, dones, lat;
      bit              slow;

      bus.start = 1'b0; bus.x1 = 16'd0; bus.y1 = 16'd0; bus.x2 = 16'd0; bus.y2 = 16'd0;
      bus.prime = 16'd0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_ctrl", 64'({bus.busy, bus.done, bus.err, bus.gf_start, bus.gf_op}), 64'd0);
      check("reset_data", 64'(|{bus.x3, bus.y3, bus.gf_in_0, bus.gf_in_1, bus.gf_prime}), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b1;

      tbl[0] = '{16'd23, 16'd3,  16'd10, 16'd9,  16'd7,  3, 1'b0, 0, 16'd17, 16'd20};
      tbl[1] = '{16'd23, 16'd9,  16'd7,  16'd3,  16'd10, 1, 1'b1, 0, 16'd17, 16'd20};
      tbl[2] = '{16'd97, 16'd2,  16'd5,  16'd4,  16'd11, 2, 1'b0, 0, 16'd3,  16'd89};
      tbl[3] = '{16'd97, 16'd10, 16'd20, 16'd13, 16'd50, 5, 1'b1, 0, 16'd77, 16'd86};
      tbl[4] = '{16'd23, 16'd5,  16'd1,  16'd5,  16'd22, 2, 1'b0, 1, 16'd0,  16'd0};
      tbl[5] = '{16'd23, 16'd0,  16'd0,  16'd0,  16'd5,  4, 1'b1, 1, 16'd0,  16'd0};
      for (int i = 0; i < 6; i++) begin
         ref_add(longint'(tbl[i].p), longint'(tbl[i].x1), longint'(tbl[i].y1),
                 longint'(tbl[i].x2), longint'(tbl[i].y2), rerr, rx3, ry3, rlam);
         run_point($sformatf("tbl%0d", i), tbl[i].p, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2,
                   tbl[i].lat, tbl[i].slow, 1'b0, 1'b0, tbl[i].err, tbl[i].x3, tbl[i].y3,
                   SIZE'(rlam));
      end

      // A second start mid-program must be ignored.
      run_point("busy_start", 16'd23, 16'd3, 16'd10, 16'd9, 16'd7, 3, 1'b0, 1'b0, 1'b1,
                0, 16'd17, 16'd20, 16'd11);

      // Field unit never answers: timeout after TMO wait cycles of step 0.
      run_point("timeout", 16'd23, 16'd3, 16'd10, 16'd9, 16'd7, 1, 1'b0, 1'b1, 1'b0,
                2, 16'd0, 16'd0, 16'd0);
      run_point("after_tmo", 16'd23, 16'd3, 16'd10, 16'd9, 16'd7, 3, 1'b0, 1'b0, 1'b0,
                0, 16'd17, 16'd20, 16'd11);

      // Reset while waiting on the step-3 multiply.
      fu_lat = 4; fu_slow = 1'b0; fu_dead = 1'b0;
      @(negedge i_clk);
      bus.start = 1'b1; bus.x1 = 16'd3; bus.y1 = 16'd10; bus.x2 = 16'd9; bus.y2 = 16'd7;
      bus.prime = 16'd23;
      @(posedge i_clk); #1;
      bus.start = 1'b0;
      k = 0; pulses = 0; dones = 0;
      while (pulses < 4 && k < 100) begin
         if (bus.gf_start) pulses++;
         @(posedge i_clk); #1;
         k++;
      end
      check("rst_mid/reached_step3", 64'(pulses), 64'd4);
      check("rst_mid/in_wait", 64'({bus.busy, bus.gf_start, bus.gf_op}), 64'({1'b1, 1'b0, 2'd2}));
      #2;
      i_rst = 1'b0;
      #1;
      check("rst_mid/ctrl_zero", 64'({bus.busy, bus.done, bus.err, bus.gf_start, bus.gf_op}), 64'd0);
      check("rst_mid/data_zero", 64'(|{bus.x3, bus.y3, bus.gf_in_0, bus.gf_in_1, bus.gf_prime}),
            64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         if (bus.done) dones++;
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         if (bus.done) dones++;
      end
      check("rst_mid/no_done", 64'(dones), 64'd0);
      run_point("rst_rerun", 16'd23, 16'd3, 16'd10, 16'd9, 16'd7, 3, 1'b0, 1'b0, 1'b0,
                0, 16'd17, 16'd20, 16'd11);

      // Randomized points, field-unit latencies and add/sub timing.
      primes[0] = 16'd23;   primes[1] = 16'd97;   primes[2] = 16'd251;
      primes[3] = 16'd1009; primes[4] = 16'd7919; primes[5] = 16'd65521;
      for (int r = 0; r < 30; r++) begin
         p  = primes[$urandom_range(0, 5)];
         x1 = SIZE'($urandom_range(0, 32'(p) - 1));
         y1 = SIZE'($urandom_range(0, 32'(p) - 1));
         x2 = SIZE'($urandom_range(0, 32'(p) - 1));
         y2 = SIZE'($urandom_range(0, 32'(p) - 1));
         if ($urandom_range(0, 7) == 0) x2 = x1;
         lat  = int'($urandom_range(1, 6));
         slow = bit'($urandom_range(0, 1));
         ref_add(longint'(p), longint'(x1), longint'(y1), longint'(x2), longint'(y2),
                 rerr, rx3, ry3, rlam);
         run_point($sformatf("rnd%0d", r), p, x1, y1, x2, y2, lat, slow, 1'b0, 1'b0,
                   rerr, SIZE'(rx3), SIZE'(ry3), SIZE'(rlam));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
